// File: rtl/dmem_arbiter.sv
// Two-port (core/debug) arbiter in front of a single-ported 32-bit data memory.
// Optional DMEM_ARB_ERR_EN: flags and suppresses accesses whose upper address bits are nonzero.
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [31:0]       c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [31:0]       c_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  output logic              err
);

  logic [7:0]  starve_q, starve_d;
  logic        c_rvalid_q, c_rvalid_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic [31:0] c_rdata_q, c_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        err_q, err_d;

  logic        starved, c_sel, d_sel, any_sel, g_we, oor;
  logic [31:0] g_addr, g_wdata;

`ifndef DMEM_ARB_ERR_EN
  logic unused_hi;
  assign unused_hi = ^g_addr[31:ADDR_W];
`endif

  always_comb begin
    starved = (starve_q == 8'(STARVE_LIM));
    // Grants are gated by rst so nothing reaches memory during reset.
    c_sel   = rst & c_req & ~starved;
    d_sel   = rst & d_req & (~c_req | starved);
    any_sel = c_sel | d_sel;
    g_we    = c_sel ? c_we    : d_we;
    g_addr  = c_sel ? c_addr  : d_addr;
    g_wdata = c_sel ? c_wdata : d_wdata;

`ifdef DMEM_ARB_ERR_EN
    oor = any_sel && ((g_addr >> ADDR_W) != '0);
`else
    oor = 1'b0;
`endif

    m_en    = any_sel & ~oor;
    m_we    = m_en & g_we;
    m_addr  = any_sel ? g_addr[ADDR_W-1:0] : '0;
    m_wdata = any_sel ? g_wdata : '0;

    starve_d = '0;
    if (d_req && !d_sel) starve_d = starved ? starve_q : starve_q + 8'd1;

    c_rvalid_d = c_sel & ~c_we;
    d_rvalid_d = d_sel & ~d_we;
    c_rdata_d  = c_rdata_q;
    d_rdata_d  = d_rdata_q;
    if (c_rvalid_d) c_rdata_d = oor ? '0 : m_rdata;
    if (d_rvalid_d) d_rdata_d = oor ? '0 : m_rdata;
    err_d = oor;

    c_gnt = c_sel;
    d_gnt = d_sel;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_q   <= '0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      d_rdata_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      c_rvalid_q <= c_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      c_rdata_q  <= c_rdata_d;
      d_rdata_q  <= d_rdata_d;
      err_q      <= err_d;
    end
  end

  assign c_rvalid = c_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign c_rdata  = c_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign err      = err_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, sets the word-address width; the memory holds 2^ADDR_W words of 32 bits.
REQ-002 Parameter STARVE_LIM, default 4, range 1..255, is the number of consecutive lost cycles after which the debug port wins.
REQ-003 clk  input  1  system clock; every register updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; the block is in reset while rst=0 at a rising clk edge.
REQ-005 c_req, c_we  input  1 each  core (MEM stage) access request and write-enable.
REQ-006 c_addr, c_wdata  input  32 each  core word address and write data.
REQ-007 c_gnt  output  1  core access accepted this cycle (combinational).
REQ-008 c_rvalid  output  1  core read data valid (registered).
REQ-009 c_rdata  output  32  core read data (registered).
REQ-010 d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata  same widths and directions as the c_* ports  debug/loader port.
REQ-011 m_en, m_we  output  1 each  memory access strobe and write strobe.
REQ-012 m_addr  output  ADDR_W  memory word address.
REQ-013 m_wdata  output  32  memory write data.
REQ-014 m_rdata  input  32  memory combinational read data for the current m_addr.
REQ-015 err  output  1  registered one-cycle pulse flagging an out-of-range access (see REQ-032).

Function
REQ-016 A transfer occurs on a port in a cycle where req=1 and gnt=1; at most one gnt is high per cycle.
REQ-017 gnt is a combinational function of the current req inputs and the starvation state; it does not depend on any prior handshake.
REQ-018 Default priority is core: c_gnt = c_req, unless the starvation override (REQ-021) is active.
REQ-019 When the core does not request, d_gnt = d_req.
REQ-020 starve_cnt (8-bit) increments each cycle that d_req=1 and d_gnt=0, and saturates at STARVE_LIM.
REQ-021 While starve_cnt == STARVE_LIM: d_gnt = d_req, c_gnt = 0, and the core stalls.
REQ-022 starve_cnt clears to 0 in any cycle where d_gnt=1 or d_req=0.
REQ-023 Memory signals for the granted port:
  - m_en = 1
  - m_we = granted we
  - m_addr = granted addr[ADDR_W-1:0]
  - m_wdata = granted wdata
REQ-024 With no grant: m_en = 0, m_we = 0, and m_addr/m_wdata are 0.
REQ-025 Read latency is 1 cycle: for a granted read in cycle N, the owning port's rvalid = 1 and rdata = m_rdata sampled in cycle N, both shown in cycle N+1.
REQ-026 rvalid is a one-cycle pulse; rdata holds its value until the next read response to that port.
REQ-027 A granted write produces no rvalid; the memory captures it at the end of the grant cycle.
REQ-028 A read in cycle N+1 to an address written in cycle N returns the new data; no bypass logic is required.
REQ-029 A new request may be granted every cycle, so back-to-back reads give rvalid on consecutive cycles.
REQ-030 A requester whose gnt=0 holds its req/we/addr/wdata stable until it is granted.

Reset
REQ-031 While rst=0, at the edge:
  - registered outputs: c_rvalid, d_rvalid and err = 0; c_rdata and d_rdata = 0
  - starve_cnt = 0
  - combinational outputs: c_gnt, d_gnt, m_en and m_we are forced to 0
  - a read granted in the cycle reset is applied produces no response after reset.

Configuration
REQ-032 With macro DMEM_ARB_ERR_EN defined, a granted access with any nonzero bit in addr[31:ADDR_W]:
  - is still granted, with m_en=0 and m_we=0
  - on a read, returns rvalid=1 with rdata=0 in the next cycle
  - pulses err=1 in the next cycle.
REQ-033 Without DMEM_ARB_ERR_EN, the upper address bits are ignored (the address wraps modulo 2^ADDR_W) and err is tied to 0.

Verification
REQ-034 Core read, c_addr=0x05 with mem[5]=0xDEADBEEF -> c_gnt=1 the same cycle; c_rvalid=1 and c_rdata=0xDEADBEEF the next cycle; d_rvalid stays 0.
REQ-035 Both ports request continuously with STARVE_LIM=4 -> c_gnt for 4 cycles, d_gnt on the 5th cycle, starve_cnt=0 afterwards; the pattern then repeats.
REQ-036 Debug write 0x12345678 to address 0x10 in cycle N, core read of 0x10 in cycle N+1 -> c_rdata=0x12345678 in cycle N+2.
REQ-037 rst=0 asserted in the cycle of a granted read -> no rvalid after reset; all outputs 0 while in reset; starve_cnt=0.
REQ-038 With DMEM_ARB_ERR_EN, read of c_addr=0x100 (ADDR_W=8) -> m_en=0; next cycle err=1, c_rvalid=1, c_rdata=0. Without the macro -> m_addr=0x00, err=0.
